// File: rtl/pixel_line_pkg.sv
// pixel_line_pkg: shared state encoding and width helper for the line capture block
package pixel_line_pkg;
  typedef enum logic [1:0] {ARM, IDLE, CAPTURE, DROP} state_e;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/line_bank_ram.sv
// line_bank_ram: two-bank simple dual-port line store with registered read
module line_bank_ram #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W:0]   raddr,
  output logic [DATA_W-1:0] rdata_q
);
  logic [DATA_W-1:0] mem [2**(ADDR_W+1)];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= !rst_n ? '0 : mem[raddr];
  end
endmodule

// File: rtl/pixel_line_capture.sv
// pixel_line_capture: captures HSYNC-framed lines into a ping-pong buffer and checks length
module pixel_line_capture
  import pixel_line_pkg::*;
#(
  parameter int IMG_WIDTH  = 8192,
  parameter int IMG_HEIGHT = 512,
  parameter int DATA_W     = 16
) (
  input  logic                              PCLK,
  input  logic                              RST,
  input  logic [DATA_W-1:0]                 Pixel_DATA,
  input  logic                              HSYNC,
  input  logic                              rd_bank,
  input  logic [width_of(IMG_WIDTH)-1:0]    rd_addr,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              line_rdy,
  output logic                              rdy_bank,
  output logic [width_of(IMG_HEIGHT)-1:0]   rdy_line,
  input  logic                              line_ack,
  output logic                              frame_done,
  output logic                              err_len,
  output logic                              err_ovf,
  input  logic                              clr_err
);
  localparam int ADDR_W = width_of(IMG_WIDTH);
  localparam int LINE_W = width_of(IMG_HEIGHT);
  localparam logic [ADDR_W:0]   LINE_LEN  = (ADDR_W+1)'(IMG_WIDTH);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(IMG_HEIGHT - 1);

  state_e            state_q, state_d;
  logic              wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [1:0]        full_q, full_d;
  logic [LINE_W-1:0] tag_q [2];
  logic [LINE_W-1:0] tag_d [2];
  logic [ADDR_W:0]   pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic              line_rdy_q, line_rdy_d, rdy_bank_q, rdy_bank_d;
  logic [LINE_W-1:0] rdy_line_q, rdy_line_d;
  logic              frame_done_q, frame_done_d, err_len_q, err_len_d, err_ovf_q, err_ovf_d;
  logic              we, commit, line_end, len_ev, ovf_ev, ack, last;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    we        = 1'b0;
    commit    = 1'b0;
    line_end  = 1'b0;
    len_ev    = 1'b0;
    ovf_ev    = 1'b0;
    case (state_q)
      ARM: if (!HSYNC) state_d = IDLE;
      IDLE: if (HSYNC) begin
        if (full_q[wr_sel_q]) begin
          ovf_ev  = 1'b1;
          state_d = DROP;
        end else begin
          we        = 1'b1;
          pix_cnt_d = 1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: if (HSYNC) begin
        if (pix_cnt_q < LINE_LEN) begin
          we        = 1'b1;
          pix_cnt_d = pix_cnt_q + 1'b1;
        end else len_ev = 1'b1;
      end else begin
        line_end  = 1'b1;
        pix_cnt_d = '0;
        state_d   = IDLE;
        commit    = pix_cnt_q == LINE_LEN;
        len_ev    = pix_cnt_q != LINE_LEN;
      end
      default: if (!HSYNC) begin
        line_end = 1'b1;
        state_d  = IDLE;
      end
    endcase
    // ack and commit always target different banks, so both apply freely
    ack    = line_ack && line_rdy_q;
    full_d = full_q;
    tag_d  = tag_q;
    if (ack) full_d[rd_sel_q] = 1'b0;
    if (commit) begin
      full_d[wr_sel_q] = 1'b1;
      tag_d[wr_sel_q]  = line_cnt_q;
    end
    wr_sel_d     = wr_sel_q ^ commit;
    rd_sel_d     = rd_sel_q ^ ack;
    last         = line_end && line_cnt_q == LAST_LINE;
    line_cnt_d   = line_end ? (last ? '0 : line_cnt_q + 1'b1) : line_cnt_q;
    frame_done_d = last;
    line_rdy_d   = |full_d;
    rdy_bank_d   = rd_sel_d;
    rdy_line_d   = tag_d[rd_sel_d];
    err_len_d    = (err_len_q & ~clr_err) | len_ev;
    err_ovf_d    = (err_ovf_q & ~clr_err) | ovf_ev;
  end

  always_ff @(posedge PCLK) begin
    if (!RST) begin
      state_q      <= ARM;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      full_q       <= '0;
      tag_q        <= '{default: '0};
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      line_rdy_q   <= 1'b0;
      rdy_bank_q   <= 1'b0;
      rdy_line_q   <= '0;
      frame_done_q <= 1'b0;
      err_len_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      full_q       <= full_d;
      tag_q        <= tag_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      line_rdy_q   <= line_rdy_d;
      rdy_bank_q   <= rdy_bank_d;
      rdy_line_q   <= rdy_line_d;
      frame_done_q <= frame_done_d;
      err_len_q    <= err_len_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  line_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (PCLK),
    .rst_n   (RST),
    .we      (we),
    .waddr   ({wr_sel_q, pix_cnt_q[ADDR_W-1:0]}),
    .wdata   (Pixel_DATA),
    .raddr   ({rd_bank, rd_addr}),
    .rdata_q (rd_data)
  );

  assign line_rdy   = line_rdy_q;
  assign rdy_bank   = rdy_bank_q;
  assign rdy_line   = rdy_line_q;
  assign frame_done = frame_done_q;
  assign err_len    = err_len_q;
  assign err_ovf    = err_ovf_q;
endmodule

// File: tb/tb_pixel_line_capture.sv
// tb_pixel_line_capture: scoreboard bench for the line capture block (IMG_WIDTH=8, IMG_HEIGHT=4)
module tb_pixel_line_capture;
  logic        PCLK, RST, HSYNC, rd_bank, line_ack, clr_err;
  logic [15:0] Pixel_DATA, rd_data;
  logic [2:0]  rd_addr;
  logic        line_rdy, rdy_bank, frame_done, err_len, err_ovf;
  logic [1:0]  rdy_line;

  typedef struct packed {
    logic            bank;
    logic [1:0]      tag;
    logic [7:0][15:0] px;
  } line_t;

  line_t sb[$];
  int    total = 0, bad = 0, fd_cnt = 0;
  int    m_full, m_line;
  bit    m_wr, m_len, m_ovf;

  pixel_line_capture #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .DATA_W(16)) dut (
    .PCLK(PCLK), .RST(RST), .Pixel_DATA(Pixel_DATA), .HSYNC(HSYNC),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
    .line_rdy(line_rdy), .rdy_bank(rdy_bank), .rdy_line(rdy_line),
    .line_ack(line_ack), .frame_done(frame_done),
    .err_len(err_len), .err_ovf(err_ovf), .clr_err(clr_err)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(negedge PCLK) if (frame_done) fd_cnt <= fd_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0; HSYNC = 1'b0; line_ack = 1'b0; clr_err = 1'b0;
    rd_bank = 1'b0; rd_addr = '0; Pixel_DATA = '0;
    repeat (3) @(posedge PCLK);
    #1 RST = 1'b1;
    m_full = 0; m_wr = 0; m_line = 0; m_len = 0; m_ovf = 0;
    sb.delete();
  endtask

  task automatic chk_errs();
    repeat (2) @(negedge PCLK);
    chk("err_len", err_len, m_len);
    chk("err_ovf", err_ovf, m_ovf);
  endtask

  task automatic send_line(input int n, input int base, input bit lat, input bit ack);
    line_t e;
    int    fb;
    bit    fd;
    fb = m_full;
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK); #1 HSYNC = 1'b1; Pixel_DATA = 16'(base + i);
    end
    @(posedge PCLK); #1 HSYNC = 1'b0; line_ack = ack;
    if (m_full == 2) m_ovf = 1;
    else begin
      if (n != 8) m_len = 1;
      if (n >= 8) begin
        e.bank = m_wr; e.tag = 2'(m_line);
        for (int j = 0; j < 8; j++) e.px[j] = 16'(base + j);
        sb.push_back(e);
        m_wr = ~m_wr;
        m_full++;
      end
    end
    if (ack && fb > 0) begin
      void'(sb.pop_front());
      m_full--;
    end
    fd = (m_line == 3);
    m_line = (m_line + 1) % 4;
    if (lat) begin
      @(negedge PCLK);
      chk("rdy_pre", line_rdy, fb > 0);
      chk("fd_pre", frame_done, 0);
      if (ack) begin @(posedge PCLK); #1 line_ack = 1'b0; end
      @(negedge PCLK);
      chk("rdy_post", line_rdy, m_full > 0);
      chk("fd_post", frame_done, fd);
      if (m_full > 0) begin
        chk("rdy_bank_post", rdy_bank, sb[0].bank);
        chk("rdy_line_post", rdy_line, sb[0].tag);
      end
    end else if (ack) begin
      @(posedge PCLK); #1 line_ack = 1'b0;
    end
  endtask

  task automatic drain_one();
    line_t e;
    int    w;
    w = 0;
    @(negedge PCLK);
    while (!line_rdy && w < 20) begin @(negedge PCLK); w++; end
    chk("rdy_wait", line_rdy, 1);
    chk("sb_has_line", sb.size() != 0, 1);
    if (!line_rdy || sb.size() == 0) return;
    e = sb.pop_front();
    chk("rdy_bank", rdy_bank, e.bank);
    chk("rdy_line", rdy_line, e.tag);
    rd_bank = e.bank;
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      @(posedge PCLK); #1;
      chk($sformatf("rd_data[%0d]", a), rd_data, e.px[a]);
    end
    line_ack = 1'b1;
    @(posedge PCLK); #1 line_ack = 1'b0;
    m_full--;
    @(negedge PCLK);
    chk("rdy_after_ack", line_rdy, m_full > 0);
    if (m_full > 0) chk("bank_after_ack", rdy_bank, sb[0].bank);
  endtask

  initial begin
    int fd0;
    do_reset();
    @(negedge PCLK);
    chk("rst_line_rdy", line_rdy, 0);
    chk("rst_rdy_bank", rdy_bank, 0);
    chk("rst_rdy_line", rdy_line, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_err_ovf", err_ovf, 0);
    chk("rst_rd_data", rd_data, 0);

    // two full lines, drained one at a time
    send_line(8, 1, 1, 0);
    drain_one();
    send_line(8, 9, 1, 0);
    drain_one();
    chk_errs();

    // third line with both banks full is dropped
    do_reset();
    send_line(8, 1, 0, 0);
    send_line(8, 9, 0, 0);
    send_line(8, 17, 0, 0);
    chk_errs();
    drain_one();
    drain_one();
    send_line(8, 25, 1, 0);
    drain_one();

    // short line then long line
    do_reset();
    send_line(5, 1, 0, 0);
    chk_errs();
    send_line(10, 11, 1, 0);
    drain_one();
    chk_errs();
    @(posedge PCLK); #1 clr_err = 1'b1;
    @(posedge PCLK); #1 clr_err = 1'b0;
    m_len = 0; m_ovf = 0;
    chk_errs();

    // one full frame of four acked lines
    do_reset();
    fd0 = fd_cnt;
    for (int k = 0; k < 4; k++) begin
      send_line(8, 100 + 8 * k, 1, 0);
      drain_one();
    end
    repeat (3) @(negedge PCLK);
    chk("frame_done_count", fd_cnt - fd0, 1);
    send_line(8, 200, 1, 0);
    drain_one();

    // reset asserted mid-line and released while the line continues
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1 HSYNC = 1'b1; Pixel_DATA = 16'(300 + i);
    end
    RST = 1'b0;
    repeat (2) begin @(posedge PCLK); #1 Pixel_DATA = Pixel_DATA + 1'b1; end
    RST = 1'b1;
    m_full = 0; m_wr = 0; m_line = 0; m_len = 0; m_ovf = 0;
    sb.delete();
    repeat (4) begin @(posedge PCLK); #1 Pixel_DATA = Pixel_DATA + 1'b1; end
    HSYNC = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      chk("rst_mid_no_rdy", line_rdy, 0);
    end
    chk_errs();
    send_line(8, 41, 1, 0);
    drain_one();

    // ack coinciding with a commit while one bank is already full
    do_reset();
    send_line(8, 1, 1, 0);
    send_line(8, 9, 1, 1);
    drain_one();
    chk_errs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
